// File: rtl/ysyx_22040088_ibuf.sv
// ----------------------------------------------------------------------------
// ysyx_22040088_ibuf
// Instruction fetch buffer sitting between the IFU and decode. It queues
// {pc, inst, jump} triples from the IFU so that decode back-pressure does not
// stall the icache, and hands them to decode in order over valid/ready.
// A branch redirect (flush) empties the buffer in a single cycle.
//
// Optional build macro:
//   IBUF_BYPASS_EN - when the buffer is empty, an incoming instruction is
//                    forwarded combinationally to decode (zero-cycle latency);
//                    if decode takes it in the same cycle it is never stored.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   flush      in   branch redirect, discards every buffered entry
//   in_valid   in   IFU presents a fetched instruction
//   in_pc      in   pc of the fetched instruction       [PC_W]
//   in_inst    in   fetched instruction word            [INST_W]
//   in_jump    in   IFU predecoded jal flag
//   in_ready   out  buffer can accept (drives IFU enable)
//   out_valid  out  head entry valid for decode
//   out_pc     out  head pc                             [PC_W]
//   out_inst   out  head instruction                    [INST_W]
//   out_jump   out  head jal flag
//   out_ready  in   decode consumes the head this cycle
//   count      out  current occupancy                   [$clog2(DEPTH+1)]
// ----------------------------------------------------------------------------
module ysyx_22040088_ibuf #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 64,
    parameter int INST_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [INST_W-1:0]          in_inst,
    input  logic                       in_jump,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [PC_W-1:0]            out_pc,
    output logic [INST_W-1:0]          out_inst,
    output logic                       out_jump,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PC_W-1:0]   pc_mem_r   [DEPTH];
    logic [INST_W-1:0] inst_mem_r [DEPTH];
    logic              jump_mem_r [DEPTH];

    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;

    logic empty_s;
    logic full_s;
    logic bypass_s;
    logic push_s;
    logic pop_s;

    assign empty_s = (count_r == {CNT_W{1'b0}});
    assign full_s  = (count_r == FULL_CNT);

    // Handshake decode: bypass detection, stored push and stored pop.
    always_comb begin
        bypass_s = 1'b0;
`ifdef IBUF_BYPASS_EN
        bypass_s = empty_s && in_valid && !flush;
`endif
        // A bypassed instruction taken by decode right away is never written.
        if (bypass_s && out_ready) begin
            push_s = 1'b0;
        end else begin
            push_s = in_valid && !full_s;
        end
        pop_s = !empty_s && out_ready;
    end

    // Output selection: stored head normally, live IFU input when bypassing.
    always_comb begin
        in_ready = !full_s;
        count    = count_r;
        if (bypass_s) begin
            out_valid = 1'b1;
            out_pc    = in_pc;
            out_inst  = in_inst;
            out_jump  = in_jump;
        end else begin
            out_valid = !empty_s;
            out_pc    = pc_mem_r[head_r];
            out_inst  = inst_mem_r[head_r];
            out_jump  = jump_mem_r[head_r];
        end
    end

    // Pointer and occupancy state; flush outranks any concurrent push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (flush) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end else begin
                tail_r <= tail_r;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end else begin
                head_r <= head_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage: cleared on reset, written at the tail on an accepted push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]   <= {PC_W{1'b0}};
                inst_mem_r[i] <= {INST_W{1'b0}};
                jump_mem_r[i] <= 1'b0;
            end
        end else if (push_s && !flush) begin
            pc_mem_r[tail_r]   <= in_pc;
            inst_mem_r[tail_r] <= in_inst;
            jump_mem_r[tail_r] <= in_jump;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]   <= pc_mem_r[i];
                inst_mem_r[i] <= inst_mem_r[i];
                jump_mem_r[i] <= jump_mem_r[i];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040088_ibuf.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22040088_ibuf
// Scoreboard bench for the instruction fetch buffer. Every accepted push puts
// the expected {pc, inst, jump} triple into a queue; the head of the queue is
// compared with the DUT outputs each cycle and popped on a consumed handshake.
// Occupancy, in_ready and out_valid are derived from the queue size.
// ----------------------------------------------------------------------------
module tb_ysyx_22040088_ibuf;

    localparam int DEPTH  = 4;
    localparam int PC_W   = 64;
    localparam int INST_W = 32;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic [PC_W-1:0]   in_pc;
    logic [INST_W-1:0] in_inst;
    logic              in_jump;
    logic              in_ready;
    logic              out_valid;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_jump;
    logic              out_ready;
    logic [CNT_W-1:0]  count;

    int err_cnt;
    int chk_cnt;

    logic [PC_W+INST_W:0] sb_q [$];

    ysyx_22040088_ibuf #(
        .DEPTH  (DEPTH),
        .PC_W   (PC_W),
        .INST_W (INST_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_jump   (in_jump),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_jump  (out_jump),
        .out_ready (out_ready),
        .count     (count)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, update the model.
    task automatic cycle(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                         input logic j, input logic rdy, input logic fl);
        logic              exp_valid;
        logic              accept;
        logic              taken;
        logic              byp;
        logic [PC_W+INST_W:0] head;
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        in_jump   = j;
        out_ready = rdy;
        flush     = fl;
        #3;
        byp = 1'b0;
`ifdef IBUF_BYPASS_EN
        byp = (sb_q.size() == 0) && v && !fl;
`endif
        exp_valid = (sb_q.size() != 0) || byp;
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        check("count", 64'(count), 64'(sb_q.size()));
        check("in_ready", 64'(in_ready), 64'(sb_q.size() != DEPTH));
        if (exp_valid) begin
            head = byp ? {pc, inst, j} : sb_q[0];
            check("out_pc", out_pc, head[PC_W+INST_W:INST_W+1]);
            check("out_inst", 64'(out_inst), 64'(head[INST_W:1]));
            check("out_jump", 64'(out_jump), 64'(head[0]));
        end
        if (fl) begin
            sb_q.delete();
        end else begin
            accept = v && (sb_q.size() != DEPTH) && !(byp && rdy);
            taken  = rdy && (sb_q.size() != 0);
            if (taken) begin
                void'(sb_q.pop_front());
            end
            if (accept) begin
                sb_q.push_back({pc, inst, j});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] pc;
        err_cnt   = 0;
        chk_cnt   = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = 64'h0;
        in_inst   = 32'h0;
        in_jump   = 1'b0;
        out_ready = 1'b0;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_out_inst", 64'(out_inst), 64'd0);
        check("rst_out_jump", 64'(out_jump), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: single push, visible next cycle; then drain.
        cycle(1'b1, 64'h8000_0000, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // 2: fill to DEPTH, fifth push refused, then drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 64'h8000_0000 + 64'(4 * i), 32'h0010_0093 + 32'(i), 1'b0, 1'b0, 1'b0);
        end
        cycle(1'b1, 64'h8000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        // Full with a concurrent pop: the push must still be refused.
        cycle(1'b1, 64'h8000_0020, 32'hBAD0_0001, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        end
        cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // 3: preload two, then 10 cycles of simultaneous push and pop.
        pc = 64'h8000_0100;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, pc, 32'h0000_1000 + 32'(i), 1'b0, 1'b0, 1'b0);
            pc = pc + 64'd4;
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, pc, 32'h0000_2000 + 32'(i), 1'b0, 1'b1, 1'b0);
            pc = pc + 64'd4;
        end

        // 4: reach count 3, flush with concurrent push and pop.
        cycle(1'b1, pc, 32'h0000_3000, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 64'h8000_1000, 32'h0000_4000, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 64'h8000_2000, 32'h0000_5000, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 64'h8000_2004, 32'h0000_5001, 1'b0, 1'b0, 1'b0);

        // 5: asynchronous reset mid-cycle with two entries held.
        cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_count", 64'(count), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_out_pc", out_pc, 64'd0);
        sb_q.delete();
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 6: jump flag travels with exactly its own entry.
        cycle(1'b1, 64'h8000_0008, 32'h0000_6000, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 64'h8000_0010, 32'h0000_006F, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 64'h8000_0014, 32'h0000_6001, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        end
        cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
